// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and baud divisor helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE      = 3'd0;
  localparam uart_state_t ST_START     = 3'd1;
  localparam uart_state_t ST_DATA      = 3'd2;
  localparam uart_state_t ST_PARITY    = 3'd3;
  localparam uart_state_t ST_STOP      = 3'd4;
  localparam uart_state_t ST_DONE      = 3'd5;
  localparam uart_state_t ST_WAIT_HIGH = 3'd6;

  // Clocks per oversample tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned bit_rate,
                                           input int unsigned oversample);
    return clk_hz / (bit_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, realigned by restart.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BIT_RATE   = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  output logic tick
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BIT_RATE, OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_div_chk
    $error("uart_baud_tick: CLK_HZ too low for BIT_RATE * OVERSAMPLE");
  end

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn || restart) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with glitch rejection, parity/framing flags and BREAK detect.
// Define UART_RX_MAJORITY_EN to vote each bit 2-of-3 over the samples around its centre.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BIT_RATE   = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 uart_rxd,
  input  logic                 uart_rx_en,
  output logic                 uart_rx_valid,
  output logic [DATA_BITS-1:0] uart_rx_data,
  output logic                 uart_rx_parity_err,
  output logic                 uart_rx_frame_err,
  output logic                 uart_rx_break
);

  localparam int unsigned SCW    = $clog2(OVERSAMPLE);
  localparam int unsigned BIW    = $clog2(DATA_BITS);
  localparam int unsigned CENTRE = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned DECIDE = CENTRE + 1;
`else
  localparam int unsigned DECIDE = CENTRE;
`endif

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > PAR_EVEN || STOP_BITS < 1 ||
      STOP_BITS > 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_param_chk
    $error("uart_rx_param: illegal parameter combination");
  end

  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic                 rxd_prev_q;
  logic                 tick;
  logic                 decide;
  logic                 bit_val;
  logic                 par_err;
  uart_state_t          state_q, state_n;
  logic [SCW-1:0]       samp_cnt_q, samp_cnt_n;
  logic [BIW-1:0]       bit_idx_q, bit_idx_n;
  logic                 stop_idx_q, stop_idx_n;
  logic [DATA_BITS-1:0] data_sr_q, data_sr_n;
  logic                 par_bit_q, par_bit_n;
  logic                 ferr_q, ferr_n;
  logic                 brk_q, brk_n;
  logic                 valid_n, break_n, perr_out_n, ferr_out_n;
  logic [DATA_BITS-1:0] data_out_n;

  // Metastability synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q     <= 2'b11;
      rxd_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], uart_rxd};
      rxd_prev_q <= sync_q[1];
    end
  end

  assign rxd_s = sync_q[1];

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BIT_RATE  (BIT_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .restart(state_q == ST_IDLE),
    .tick   (tick)
  );

  assign decide = tick && (samp_cnt_q == SCW'(DECIDE));

`ifdef UART_RX_MAJORITY_EN
  logic maj_lo_q, maj_mid_q;

  // Samples just before and at the centre; the third vote is the live sample.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      maj_lo_q  <= 1'b1;
      maj_mid_q <= 1'b1;
    end else if (tick) begin
      if (samp_cnt_q == SCW'(CENTRE - 1)) maj_lo_q <= rxd_s;
      if (samp_cnt_q == SCW'(CENTRE)) maj_mid_q <= rxd_s;
    end
  end

  assign bit_val = (maj_lo_q & maj_mid_q) | (maj_lo_q & rxd_s) | (maj_mid_q & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  always_comb begin
    par_err = 1'b0;
    if (PARITY == PAR_ODD) par_err = ~(^data_sr_q ^ par_bit_q);
    else if (PARITY == PAR_EVEN) par_err = ^data_sr_q ^ par_bit_q;
  end

  always_comb begin
    state_n    = state_q;
    samp_cnt_n = samp_cnt_q;
    bit_idx_n  = bit_idx_q;
    stop_idx_n = stop_idx_q;
    data_sr_n  = data_sr_q;
    par_bit_n  = par_bit_q;
    ferr_n     = ferr_q;
    brk_n      = brk_q;
    valid_n    = 1'b0;
    break_n    = 1'b0;
    data_out_n = uart_rx_data;
    perr_out_n = uart_rx_parity_err;
    ferr_out_n = uart_rx_frame_err;

    if (tick) begin
      samp_cnt_n = (samp_cnt_q == SCW'(OVERSAMPLE - 1)) ? '0 : samp_cnt_q + SCW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        samp_cnt_n = '0;
        bit_idx_n  = '0;
        stop_idx_n = 1'b0;
        par_bit_n  = 1'b0;
        ferr_n     = 1'b0;
        brk_n      = 1'b0;
        if (uart_rx_en && rxd_prev_q && !rxd_s) state_n = ST_START;
      end
      ST_START: begin
        if (decide) state_n = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide) begin
          data_sr_n = {bit_val, data_sr_q[DATA_BITS-1:1]};
          bit_idx_n = bit_idx_q + BIW'(1);
          if (bit_idx_q == BIW'(DATA_BITS - 1)) begin
            bit_idx_n = '0;
            state_n   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (decide) begin
          par_bit_n = bit_val;
          state_n   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide) begin
          ferr_n     = ferr_q | ~bit_val;
          stop_idx_n = stop_idx_q + 1'b1;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            state_n = ST_DONE;
            // An all-zero frame with a low stop bit is a held-low line, not a word.
            if (data_sr_q == '0 && !par_bit_q && ferr_n) begin
              brk_n   = 1'b1;
              break_n = 1'b1;
            end else begin
              valid_n    = 1'b1;
              data_out_n = data_sr_q;
              perr_out_n = par_err;
              ferr_out_n = ferr_n;
            end
          end
        end
      end
      ST_DONE: begin
        state_n = brk_q ? ST_WAIT_HIGH : ST_IDLE;
      end
      ST_WAIT_HIGH: begin
        if (rxd_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_sr_q  <= '0;
      par_bit_q  <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      samp_cnt_q <= samp_cnt_n;
      bit_idx_q  <= bit_idx_n;
      stop_idx_q <= stop_idx_n;
      data_sr_q  <= data_sr_n;
      par_bit_q  <= par_bit_n;
      ferr_q     <= ferr_n;
      brk_q      <= brk_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      uart_rx_valid      <= 1'b0;
      uart_rx_data       <= '0;
      uart_rx_parity_err <= 1'b0;
      uart_rx_frame_err  <= 1'b0;
      uart_rx_break      <= 1'b0;
    end else begin
      uart_rx_valid      <= valid_n;
      uart_rx_data       <= data_out_n;
      uart_rx_parity_err <= perr_out_n;
      uart_rx_frame_err  <= ferr_out_n;
      uart_rx_break      <= break_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations checked against a frame-level model.
module tb_uart_rx_param;

  localparam int unsigned CLK_HZ = 50000000;
  // Bit periods the receivers actually realise (integer divisor times oversampling).
  localparam int BP_A = int'((CLK_HZ / (115200 * 16)) * 16);
  localparam int BP_B = int'((CLK_HZ / (1000000 * 8)) * 8);

  typedef struct packed {
    logic       brk;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic rxd_a, rxd_b, rxd_c;
  logic en_a, en_b, en_c;
  logic v_a, v_b, v_c;
  logic [7:0] d_a;
  logic [6:0] d_b;
  logic [7:0] d_c;
  logic pe_a, pe_b, pe_c, fe_a, fe_b, fe_c, bk_a, bk_b, bk_c;

  int total = 0;
  int bad = 0;
  bit rst_done = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int valid_cnt[3];
  int brk_cnt[3];
  logic [8:0] last_data[3];
  logic last_perr[3];
  logic last_ferr[3];

  always #10 clk = ~clk;

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(115200), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(16)) dut_a (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_a), .uart_rx_en(en_a),
    .uart_rx_valid(v_a), .uart_rx_data(d_a), .uart_rx_parity_err(pe_a),
    .uart_rx_frame_err(fe_a), .uart_rx_break(bk_a));

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(1000000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(1), .OVERSAMPLE(8)) dut_b (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_b), .uart_rx_en(en_b),
    .uart_rx_valid(v_b), .uart_rx_data(d_b), .uart_rx_parity_err(pe_b),
    .uart_rx_frame_err(fe_b), .uart_rx_break(bk_b));

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BIT_RATE(1000000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(2), .OVERSAMPLE(8)) dut_c (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_c), .uart_rx_en(en_c),
    .uart_rx_valid(v_c), .uart_rx_data(d_c), .uart_rx_parity_err(pe_c),
    .uart_rx_frame_err(fe_c), .uart_rx_break(bk_c));

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Frame-level expectation from the line content alone.
  function automatic exp_t model(input logic [8:0] d, input int nbits, input int pmode,
                                 input logic pbit, input logic [1:0] stops, input int nstop);
    exp_t e;
    logic [8:0] m;
    int ones;
    m = d & 9'((1 << nbits) - 1);
    ones = $countones(m) + ((pmode != 0 && pbit) ? 1 : 0);
    e.data = m;
    e.ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    e.perr = (pmode == 1) ? (ones % 2 == 0) : (pmode == 2) ? (ones % 2 == 1) : 1'b0;
    e.brk  = (m == 9'd0) && (pmode == 0 || !pbit) && e.ferr;
    return e;
  endfunction

  function automatic int qsize(input int w);
    case (w)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic void push(input int w, input exp_t e);
    case (w)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endfunction

  function automatic exp_t pop(input int w);
    exp_t e;
    case (w)
      0: e = q_a.pop_front();
      1: e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
    return e;
  endfunction

  function automatic void observe(input int w, input logic v, input logic b,
                                  input logic [8:0] d, input logic pe, input logic fe);
    exp_t e;
    if (v !== 1'b1 && b !== 1'b1) return;
    if (v === 1'b1) begin
      valid_cnt[w]++;
      last_data[w] = d;
      last_perr[w] = pe;
      last_ferr[w] = fe;
    end
    if (b === 1'b1) brk_cnt[w]++;
    if (qsize(w) == 0) begin
      chk($sformatf("dut%0d_unexpected_event", w), 32'({v, b}), 32'd0);
      return;
    end
    e = pop(w);
    chk($sformatf("dut%0d_kind", w), 32'({v, b}), 32'({~e.brk, e.brk}));
    if (!e.brk) begin
      chk($sformatf("dut%0d_data", w), 32'(d), 32'(e.data));
      chk($sformatf("dut%0d_parity_err", w), 32'(pe), 32'(e.perr));
      chk($sformatf("dut%0d_frame_err", w), 32'(fe), 32'(e.ferr));
    end
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_done) begin
      observe(0, v_a, bk_a, {1'b0, d_a}, pe_a, fe_a);
      observe(1, v_b, bk_b, {2'b0, d_b}, pe_b, fe_b);
      observe(2, v_c, bk_c, {1'b0, d_c}, pe_c, fe_c);
    end
  end

  task automatic line(input int w, input logic v);
    case (w)
      0: rxd_a = v;
      1: rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int w, input logic [8:0] d, input int nbits, input int pmode,
                      input logic pbit, input logic [1:0] stops, input int nstop,
                      input int bp, input bit expect_evt);
    if (expect_evt) push(w, model(d, nbits, pmode, pbit, stops, nstop));
    line(w, 1'b0);
    wait_clks(bp);
    for (int i = 0; i < nbits; i++) begin
      line(w, d[i]);
      wait_clks(bp);
    end
    if (pmode != 0) begin
      line(w, pbit);
      wait_clks(bp);
    end
    for (int i = 0; i < nstop; i++) begin
      line(w, stops[i]);
      wait_clks(bp);
    end
    line(w, 1'b1);
  endtask

  task automatic wait_drain(input int w, input int budget, input string name);
    int n;
    n = 0;
    while (qsize(w) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(qsize(w)), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_valid_a"}, 32'(v_a), 32'd0);
    chk({tag, "_data_a"}, 32'(d_a), 32'd0);
    chk({tag, "_perr_a"}, 32'(pe_a), 32'd0);
    chk({tag, "_ferr_a"}, 32'(fe_a), 32'd0);
    chk({tag, "_break_a"}, 32'(bk_a), 32'd0);
    chk({tag, "_data_b"}, 32'(d_b), 32'd0);
    chk({tag, "_data_c"}, 32'(d_c), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_cnt[i] = 0;
      brk_cnt[i] = 0;
      last_data[i] = '0;
      last_perr[i] = 1'b0;
      last_ferr[i] = 1'b0;
    end
    wait_clks(4);
    check_cleared("reset");
    resetn = 1'b1;
    rst_done = 1'b1;
    wait_clks(20);

    // 8N1 0xA5
    send(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, BP_A, 1'b1);
    wait_drain(0, 2 * BP_A, "a5_drain");
    chk("a5_data_literal", 32'(last_data[0]), 32'h0A5);
    chk("a5_ferr_literal", 32'(last_ferr[0]), 32'd0);
    wait_clks(BP_A);

    // 0.3-bit low glitch, then 0x3C
    line(0, 1'b0);
    wait_clks(BP_A * 3 / 10);
    line(0, 1'b1);
    wait_clks(2 * BP_A);
    chk("glitch_no_event", 32'(valid_cnt[0] + brk_cnt[0]), 32'd1);
    send(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1, BP_A, 1'b1);
    wait_drain(0, 2 * BP_A, "3c_drain");
    chk("3c_data_literal", 32'(last_data[0]), 32'h03C);
    wait_clks(BP_A);

    // Line held low for two frame times: one break, then 0x81
    push(0, '{brk: 1'b1, data: 9'd0, perr: 1'b0, ferr: 1'b1});
    line(0, 1'b0);
    wait_clks(20 * BP_A);
    chk("break_count_literal", 32'(brk_cnt[0]), 32'd1);
    chk("break_no_valid", 32'(valid_cnt[0]), 32'd2);
    line(0, 1'b1);
    wait_clks(2 * BP_A);
    send(0, 9'h081, 8, 0, 1'b0, 2'b11, 1, BP_A, 1'b1);
    wait_drain(0, 2 * BP_A, "81_drain");
    chk("81_data_literal", 32'(last_data[0]), 32'h081);
    wait_clks(BP_A);

    // 0x12 with the stop bit low: framing error, not a break
    send(0, 9'h012, 8, 0, 1'b0, 2'b00, 1, BP_A, 1'b1);
    wait_drain(0, 2 * BP_A, "12_drain");
    chk("12_ferr_literal", 32'(last_ferr[0]), 32'd1);
    chk("12_no_break", 32'(brk_cnt[0]), 32'd1);
    wait_clks(2 * BP_A);

    // 7E1: 0x55 carries four ones, so the even parity bit must be 0
    send(1, 9'h055, 7, 2, 1'b1, 2'b11, 1, BP_B, 1'b1);
    wait_drain(1, 4 * BP_B, "55_bad_drain");
    chk("55_bad_perr_literal", 32'(last_perr[1]), 32'd1);
    wait_clks(2 * BP_B);
    send(1, 9'h055, 7, 2, 1'b0, 2'b11, 1, BP_B, 1'b1);
    wait_drain(1, 4 * BP_B, "55_good_drain");
    chk("55_good_perr_literal", 32'(last_perr[1]), 32'd0);
    wait_clks(2 * BP_B);

    // Receiver disabled in IDLE ignores a frame; disabling mid-frame does not abort it
    en_b = 1'b0;
    send(1, 9'h02A, 7, 2, 1'b1, 2'b11, 1, BP_B, 1'b0);
    wait_clks(3 * BP_B);
    chk("disabled_no_valid", 32'(valid_cnt[1]), 32'd2);
    en_b = 1'b1;
    wait_clks(2);
    fork
      send(1, 9'h033, 7, 2, 1'b0, 2'b11, 1, BP_B, 1'b1);
      begin
        wait_clks(3 * BP_B);
        en_b = 1'b0;
      end
    join
    wait_drain(1, 4 * BP_B, "33_drain");
    chk("33_data_literal", 32'(last_data[1]), 32'h033);
    en_b = 1'b1;
    wait_clks(2 * BP_B);

    // 8N2 back-to-back frames with no idle gap
    send(2, 9'h001, 8, 0, 1'b0, 2'b11, 2, BP_B, 1'b1);
    send(2, 9'h002, 8, 0, 1'b0, 2'b11, 2, BP_B, 1'b1);
    wait_drain(2, 4 * BP_B, "b2b_drain");
    chk("b2b_count_literal", 32'(valid_cnt[2]), 32'd2);
    chk("b2b_last_literal", 32'(last_data[2]), 32'h002);
    wait_clks(2 * BP_B);

    // Reset pulse in the middle of 0xFF, then a clean 0x0F
    fork
      send(0, 9'h0FF, 8, 0, 1'b0, 2'b11, 1, BP_A, 1'b0);
      begin
        wait_clks(3 * BP_A + 100);
        resetn = 1'b0;
        wait_clks(1);
        resetn = 1'b1;
        check_cleared("midreset");
      end
    join
    wait_clks(2 * BP_A);
    chk("aborted_no_valid", 32'(valid_cnt[0]), 32'd4);
    send(0, 9'h00F, 8, 0, 1'b0, 2'b11, 1, BP_A, 1'b1);
    wait_drain(0, 2 * BP_A, "0f_drain");
    chk("0f_data_literal", 32'(last_data[0]), 32'h00F);
    wait_clks(BP_A);

    chk("a_valid_total", 32'(valid_cnt[0]), 32'd5);
    chk("a_break_total", 32'(brk_cnt[0]), 32'd1);
    chk("b_valid_total", 32'(valid_cnt[1]), 32'd3);
    chk("bc_break_total", 32'(brk_cnt[1] + brk_cnt[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
